// File: rtl/rsa_pkg.sv
// Shared constants for the RSA modular-exponentiation datapath.
// Holds the default result width and result-queue depth used by the core,
// the result capture FIFO and the SPI/host readout logic, plus a small
// elaboration-time helper for checking depth parameters.
package rsa_pkg;

   localparam int RSA_WIDTH      = 10;
   localparam int RSA_FIFO_DEPTH = 4;

   // True when n is a positive power of two.
   function automatic bit is_pow2(input int n);
      return (n > 0) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/result_capture_fifo_if.sv
// Readout handshake between the result capture FIFO and the SPI/host
// readout logic.
//   c_valid : head entry available (driven by the FIFO)
//   c_ready : consumer ready to take the head entry (driven by the reader)
//   C_ex    : head entry, all zeros when c_valid is low (driven by the FIFO)
// Modports: master = FIFO side, slave = reader side.
interface result_capture_fifo_if
   import rsa_pkg::*;
#(
   parameter int WIDTH = RSA_WIDTH
);

   logic             c_valid;
   logic             c_ready;
   logic [WIDTH-1:0] C_ex;

   modport master (
      output c_valid,
      output C_ex,
      input  c_ready
   );

   modport slave (
      input  c_valid,
      input  C_ex,
      output c_ready
   );

endinterface

// File: rtl/result_capture_mem.sv
// DEPTH x WIDTH register array holding queued exponentiation results.
// Ports:
//   clk   : write clock, rising edge
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (asynchronous read)
//   rdata : word stored at raddr
// Contents are not reset; the owning FIFO never presents an entry that has
// not been written since its pointers were last reset.
module result_capture_mem
   import rsa_pkg::*;
#(
   parameter int WIDTH = RSA_WIDTH,
   parameter int DEPTH = RSA_FIFO_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/result_capture_fifo.sv
// Result capture FIFO at the output of the RSA modular-exponentiation core.
// Every end-of-conversion strobe (while enabled) queues R_i; queued results
// drain first-word-fall-through over a valid/ready handshake. A capture that
// finds the queue full with no simultaneous pop is dropped and latches the
// sticky overflow flag.
// Ports:
//   clk      : system clock, rising edge
//   rstb     : asynchronous active-low reset
//   en       : block enable; when low neither capture nor pop happens
//   eoc      : end-of-conversion strobe, one cycle per result
//   R_i      : result word, valid in the eoc cycle
//   clr_ovf  : synchronous clear of overflow (independent of en)
//   rd       : readout handshake (c_valid, c_ready, C_ex)
//   full     : count == DEPTH
//   empty    : count == 0
//   count    : number of stored entries
//   overflow : sticky, a capture was dropped
module result_capture_fifo
   import rsa_pkg::*;
#(
   parameter int WIDTH = RSA_WIDTH,
   parameter int DEPTH = RSA_FIFO_DEPTH,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rstb,
   input  logic                 en,
   input  logic                 eoc,
   input  logic [WIDTH-1:0]     R_i,
   input  logic                 clr_ovf,
   result_capture_fifo_if.master rd,
   output logic                 full,
   output logic                 empty,
   output logic [CW-1:0]        count,
   output logic                 overflow
);

   localparam int AW = $clog2(DEPTH);
   // One extra wrap bit distinguishes full from empty when the address
   // bits of both pointers coincide.
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

   if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_bad_depth
      $error("result_capture_fifo: DEPTH must be a power of two and at least 2");
   end

   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    occ;
   logic             push;
   logic             pop;
   logic             drop;
   logic             valid;
   logic [WIDTH-1:0] head;

   // Occupancy follows directly from the pointer difference; with a
   // power-of-two depth the modulo-2^PW subtraction is exact.
   assign occ   = wr_ptr - rd_ptr;
   assign full  = (occ == DEPTH_P);
   assign empty = (occ == '0);
   assign count = CW'(occ);
   assign valid = !empty;

   // A full queue still accepts a word when the head leaves in the same cycle.
   assign pop  = en & valid & rd.c_ready;
   assign push = en & eoc & (!full | pop);
   assign drop = en & eoc & full & !pop;

   // Pointer state
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

   // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (clr_ovf) begin
         overflow <= 1'b0;
      end
   end

   result_capture_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (R_i),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (head)
   );

   // Gate the head word so stale storage never reaches the reader; this also
   // forces zeros the instant reset empties the pointers.
   assign rd.c_valid = valid;
   assign rd.C_ex    = valid ? head : '0;

endmodule
